// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding,
// the default operand width and the bit-counter sizing rule.
package serial_subtractor_pkg;

  // Default operand/result width; legal range is 2..32.
  localparam int DEFAULT_WIDTH = 8;

  // Controller states. The encoding is fixed so the debug port reads the
  // same values in every instance.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit counter is one bit wider than needed to index WIDTH bits, so that
  // WIDTH itself is representable even for power-of-two widths.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_half_subtractor.sv
// Half subtractor: diff = a - b for single bits.
// diff is the XOR of the inputs, and borrow is set only for 0 - 1.
// Two of these plus an OR on the borrows make a full-subtractor cell.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b;
  assign borrow = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes diff = a - b (unsigned, modulo 2^WIDTH)
// one bit per clock, LSB first, using a single full-subtractor cell and a
// borrow flop.
//
// Handshake: start is sampled only in IDLE; the edge that sees start=1 in
// IDLE captures a and b, and the operands may change freely afterwards.
// busy is high from the cycle after that edge through the DONE cycle.
// done is a one-cycle pulse, and diff/borrow_out are valid from that cycle.
// They hold until the next done. start seen while busy is dropped, not
// queued. If start is held high, a new operation begins one cycle after
// DONE.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic [1:0]       dbg_state
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  // Controller state
  state_t r_state;
  state_t w_next_state;

  // Datapath registers. r_res_sh holds the WIDTH-1 result bits produced so
  // far. The final bit goes straight from the cell into the result on the
  // last edge, so no bit of this register is ever left unread.
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-2:0] r_res_sh;
  logic             r_brw;
  logic [CW-1:0]    r_cnt;

  // Registered outputs
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow_out;
  logic             r_busy;

  // Output-decode strobes
  logic w_load;
  logic w_step;
  logic w_done;

  // Full-subtractor cell signals
  logic             w_d_ab;
  logic             w_brw_ab;
  logic             w_d;
  logic             w_brw_in;
  logic             w_brw_next;
  logic             w_last;
  logic [WIDTH-1:0] w_result;

  // First stage: a0 - b0
  half_subtractor u_hs_ab (
    .a      (r_a_sh[0]),
    .b      (r_b_sh[0]),
    .diff   (w_d_ab),
    .borrow (w_brw_ab)
  );

  // Second stage: subtract the incoming borrow
  half_subtractor u_hs_brw (
    .a      (w_d_ab),
    .b      (r_brw),
    .diff   (w_d),
    .borrow (w_brw_in)
  );

  // Only one of the two stages can borrow, so an OR gives the cell's borrow.
  assign w_brw_next = w_brw_ab | w_brw_in;
  assign w_last     = (r_cnt == LAST_CNT);
  // The new bit enters at the MSB above the bits already produced.
  assign w_result   = {w_d, r_res_sh};

  // State register: async reset to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE on last bit, DONE -> IDLE
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_next_state = ST_RUN;
      ST_RUN:  if (w_last) w_next_state = ST_DONE;
      ST_DONE:             w_next_state = ST_IDLE;
      default:             w_next_state = ST_IDLE;
    endcase
  end

  // Output decode: load strobe, per-bit step strobe and done pulse
  always_comb begin
    w_load = 1'b0;
    w_step = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_IDLE: w_load = start;
      ST_RUN:  w_step = 1'b1;
      ST_DONE: w_done = 1'b1;
      default: ;
    endcase
  end

  // Serial datapath: capture operands on accepted start, shift one bit per RUN edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_brw    <= 1'b0;
      r_cnt    <= '0;
    end else if (w_load) begin
      r_a_sh   <= a;
      r_b_sh   <= b;
      r_res_sh <= '0;
      r_brw    <= 1'b0;
      r_cnt    <= '0;
    end else if (w_step) begin
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      r_res_sh <= w_result[WIDTH-1:1];
      r_brw    <= w_brw_next;
      r_cnt    <= r_cnt + CW'(1);
    end
  end

  // Result and busy registers: result updates only on the final RUN edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_busy <= (w_next_state != ST_IDLE);
      if (w_step && w_last) begin
        r_diff       <= w_result;
        r_borrow_out <= w_brw_next;
      end
    end
  end

  assign busy       = r_busy;
  assign done       = w_done;
  assign diff       = r_diff;
  assign borrow_out = r_borrow_out;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed scenarios at WIDTH=8, random sweeps
// at WIDTH=8 and WIDTH=16, and a truth-table check of half_subtractor.
// Expected results come from plain unsigned arithmetic: diff = a - b
// truncated to W bits, and borrow_out = (a < b).
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  localparam int W8  = 8;
  localparam int W16 = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic           start8, busy8, done8, brw8;
  logic [W8-1:0]  a8, b8, diff8;
  logic [1:0]     st8;
  logic           start16, busy16, done16, brw16;
  logic [W16-1:0] a16, b16, diff16;
  logic [1:0]     st16;
  logic           hs_a, hs_b, hs_d, hs_brw;

  serial_subtractor #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(brw8),
    .dbg_state(st8)
  );

  serial_subtractor #(.WIDTH(W16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .diff(diff16), .borrow_out(brw16),
    .dbg_state(st16)
  );

  half_subtractor u_hs (.a(hs_a), .b(hs_b), .diff(hs_d), .borrow(hs_brw));

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [W8:0]  exp_q8[$];   // {borrow_out, diff}
  logic [W16:0] exp_q16[$];

  // Reference model: plain unsigned arithmetic
  function automatic logic [W8:0] model8(input logic [W8-1:0] x, input logic [W8-1:0] y);
    logic [W8-1:0] d;
    d = W8'(x - y);
    return {(x < y), d};
  endfunction

  function automatic logic [W16:0] model16(input logic [W16-1:0] x, input logic [W16-1:0] y);
    logic [W16-1:0] d;
    d = W16'(x - y);
    return {(x < y), d};
  endfunction

  // ---------------- driver tasks ----------------
  // One WIDTH=8 operation: start raised for one cycle. j counts negedges
  // after the accepting edge. Records done latency, busy/done counts,
  // whether diff/borrow_out stayed stable during RUN, and the result.
  task automatic op8(input logic [W8-1:0] ia, input logic [W8-1:0] ib,
                     output int lat, output int n_busy, output int n_done,
                     output logic held_ok, output logic [W8-1:0] got_diff,
                     output logic got_brw);
    logic [W8-1:0] prev_diff;
    logic          prev_brw;
    @(negedge clk);
    start8 = 1'b1; a8 = ia; b8 = ib;
    prev_diff = diff8; prev_brw = brw8;
    lat = -1; n_busy = 0; n_done = 0; held_ok = 1'b1;
    got_diff = '0; got_brw = 1'b0;
    for (int j = 1; j <= W8 + 6; j++) begin
      @(negedge clk);
      if (j == 1) begin
        start8 = 1'b0; a8 = W8'($urandom); b8 = W8'($urandom);
      end
      if (busy8) n_busy++;
      if (j <= W8 && (diff8 !== prev_diff || brw8 !== prev_brw)) held_ok = 1'b0;
      if (done8) begin
        n_done++;
        if (lat < 0) begin lat = j; got_diff = diff8; got_brw = brw8; end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; start8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy8 got=%b exp=0", busy8); end
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done8 got=%b exp=0", done8); end
    checks++; if (diff8 !== '0) begin errors++; $display("FAIL reset_diff8 got=%h exp=00", diff8); end
    checks++; if (brw8 !== 1'b0) begin errors++; $display("FAIL reset_brw8 got=%b exp=0", brw8); end
    checks++; if (st8 !== 2'd0) begin errors++; $display("FAIL reset_state8 got=%0d exp=0", st8); end
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL reset_busy16 got=%b exp=0", busy16); end
    checks++; if (diff16 !== '0) begin errors++; $display("FAIL reset_diff16 got=%h exp=0000", diff16); end
    checks++; if (brw16 !== 1'b0) begin errors++; $display("FAIL reset_brw16 got=%b exp=0", brw16); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (st8 !== 2'd0 || busy8 !== 1'b0) begin errors++; $display("FAIL idle_no_start state=%0d busy=%b exp=0/0", st8, busy8); end
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL idle_done got=%b exp=0", done8); end
  endtask

  task automatic test_half_subtractor();
    logic [1:0] e;
    for (int v = 0; v < 4; v++) begin
      hs_a = v[1]; hs_b = v[0];
      #1;
      e = 2'({1'b0, hs_a} - {1'b0, hs_b});  // {borrow, diff}
      checks++; if (hs_d !== e[0]) begin errors++; $display("FAIL hs_diff a=%b b=%b got=%b exp=%b", hs_a, hs_b, hs_d, e[0]); end
      checks++; if (hs_brw !== e[1]) begin errors++; $display("FAIL hs_borrow a=%b b=%b got=%b exp=%b", hs_a, hs_b, hs_brw, e[1]); end
    end
  endtask

  task automatic test_directed();
    logic [W8-1:0] va [5];
    logic [W8-1:0] vb [5];
    logic [W8:0]   e;
    int lat, nb, nd;
    logic held;
    logic [W8-1:0] gd;
    logic gb;
    va = '{8'd5, 8'd3, 8'h00, 8'hFF, 8'hA5};
    vb = '{8'd3, 8'd5, 8'h01, 8'h00, 8'hA5};
    for (int i = 0; i < 5; i++) begin
      e = model8(va[i], vb[i]);
      op8(va[i], vb[i], lat, nb, nd, held, gd, gb);
      checks++; if (gd !== e[W8-1:0]) begin errors++; $display("FAIL dir_diff a=%h b=%h got=%h exp=%h", va[i], vb[i], gd, e[W8-1:0]); end
      checks++; if (gb !== e[W8]) begin errors++; $display("FAIL dir_borrow a=%h b=%h got=%b exp=%b", va[i], vb[i], gb, e[W8]); end
      checks++; if (lat != W8 + 1) begin errors++; $display("FAIL dir_latency a=%h b=%h got=%0d exp=%0d", va[i], vb[i], lat, W8 + 1); end
      checks++; if (nb != W8 + 1) begin errors++; $display("FAIL dir_busy_cycles a=%h b=%h got=%0d exp=%0d", va[i], vb[i], nb, W8 + 1); end
      checks++; if (nd != 1) begin errors++; $display("FAIL dir_done_pulses a=%h b=%h got=%0d exp=1", va[i], vb[i], nd); end
      checks++; if (held !== 1'b1) begin errors++; $display("FAIL dir_hold_during_run a=%h b=%h got=%b exp=1", va[i], vb[i], held); end
    end
  endtask

  task automatic test_start_mid_run();
    logic [W8:0] e;
    int nd;
    logic [W8-1:0] gd;
    logic gb;
    e = model8(8'd50, 8'd8);
    nd = 0; gd = '0; gb = 1'b0;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd50; b8 = 8'd8;
    for (int j = 1; j <= 2 * W8 + 8; j++) begin
      @(negedge clk);
      if (j == 1) start8 = 1'b0;
      if (j == 3) begin start8 = 1'b1; a8 = 8'd9; b8 = 8'd1; end
      if (j == 4) start8 = 1'b0;
      if (done8) begin nd++; if (nd == 1) begin gd = diff8; gb = brw8; end end
    end
    checks++; if (nd != 1) begin errors++; $display("FAIL midstart_done_pulses got=%0d exp=1", nd); end
    checks++; if ({gb, gd} !== e) begin errors++; $display("FAIL midstart_result got=%b/%h exp=%b/%h", gb, gd, e[W8], e[W8-1:0]); end
  endtask

  task automatic test_back_to_back();
    logic [W8-1:0] va [3];
    logic [W8-1:0] vb [3];
    logic [W8:0] got, e;
    int jd [3];
    int nd;
    va = '{8'd100, 8'd128, 8'd7};
    vb = '{8'd37,  8'd128, 8'd200};
    nd = 0;
    @(negedge clk);
    start8 = 1'b1; a8 = va[0]; b8 = vb[0];
    exp_q8.push_back(model8(va[0], vb[0]));
    for (int j = 1; j <= 3 * (W8 + 2) + 10; j++) begin
      @(negedge clk);
      if (done8 && nd < 3) begin
        jd[nd] = j;
        got = {brw8, diff8};
        e = exp_q8.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL b2b_result op=%0d got=%h exp=%h", nd, got, e); end
        nd++;
        if (nd < 3) begin
          a8 = va[nd]; b8 = vb[nd];
          exp_q8.push_back(model8(va[nd], vb[nd]));
        end else begin
          start8 = 1'b0;
        end
      end else if (done8) begin
        nd++;
      end
    end
    start8 = 1'b0;
    checks++; if (nd != 3) begin errors++; $display("FAIL b2b_done_pulses got=%0d exp=3", nd); end
    if (nd >= 3) begin
      checks++; if (jd[1] - jd[0] != W8 + 2) begin errors++; $display("FAIL b2b_spacing01 got=%0d exp=%0d", jd[1] - jd[0], W8 + 2); end
      checks++; if (jd[2] - jd[1] != W8 + 2) begin errors++; $display("FAIL b2b_spacing12 got=%0d exp=%0d", jd[2] - jd[1], W8 + 2); end
    end
    exp_q8.delete();
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL b2b_idle_after got_busy=%b exp=0", busy8); end
  endtask

  task automatic test_reset_mid_run();
    int nd, lat, nb;
    logic held;
    logic [W8-1:0] gd;
    logic gb;
    logic [W8:0] e;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd200; b8 = 8'd100;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      if (j == 1) start8 = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy8); end
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL rstmid_done got=%b exp=0", done8); end
    checks++; if (diff8 !== '0) begin errors++; $display("FAIL rstmid_diff got=%h exp=00", diff8); end
    checks++; if (brw8 !== 1'b0) begin errors++; $display("FAIL rstmid_borrow got=%b exp=0", brw8); end
    checks++; if (st8 !== 2'd0) begin errors++; $display("FAIL rstmid_state got=%0d exp=0", st8); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int j = 0; j < W8 + 6; j++) begin
      @(negedge clk);
      if (done8) nd++;
    end
    checks++; if (nd != 0) begin errors++; $display("FAIL rstmid_no_done got=%0d exp=0", nd); end
    e = model8(8'd200, 8'd100);
    op8(8'd200, 8'd100, lat, nb, nd, held, gd, gb);
    checks++; if (gd !== e[W8-1:0]) begin errors++; $display("FAIL rstmid_fresh_diff got=%h exp=%h", gd, e[W8-1:0]); end
    checks++; if (gb !== e[W8]) begin errors++; $display("FAIL rstmid_fresh_borrow got=%b exp=%b", gb, e[W8]); end
    checks++; if (lat != W8 + 1) begin errors++; $display("FAIL rstmid_fresh_latency got=%0d exp=%0d", lat, W8 + 1); end
  endtask

  task automatic test_random_w8();
    logic [W8-1:0] ra, rb;
    logic [W8:0] e;
    int waited;
    for (int i = 0; i < 1000; i++) begin
      ra = W8'($urandom_range(0, 255));
      rb = W8'($urandom_range(0, 255));
      if (i == 0) begin ra = 8'h00; rb = 8'hFF; end
      if (i == 1) begin ra = 8'hFF; rb = 8'hFF; end
      exp_q8.push_back(model8(ra, rb));
      @(negedge clk);
      start8 = 1'b1; a8 = ra; b8 = rb;
      @(negedge clk);
      start8 = 1'b0;
      waited = 0;
      while (done8 !== 1'b1 && waited < W8 + 4) begin @(negedge clk); waited++; end
      e = exp_q8.pop_front();
      checks++;
      if (done8 !== 1'b1) begin
        errors++; $display("FAIL rand8_timeout a=%h b=%h", ra, rb);
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
      end else if ({brw8, diff8} !== e) begin
        errors++; $display("FAIL rand8 a=%h b=%h got=%b/%h exp=%b/%h", ra, rb, brw8, diff8, e[W8], e[W8-1:0]);
      end
    end
  endtask

  task automatic test_random_w16();
    logic [W16-1:0] ra, rb;
    logic [W16:0] e;
    int waited;
    for (int i = 0; i < 1000; i++) begin
      ra = W16'($urandom_range(0, 65535));
      rb = W16'($urandom_range(0, 65535));
      if (i == 0) begin ra = 16'h0000; rb = 16'h0001; end
      if (i == 1) begin ra = 16'hFFFF; rb = 16'h0000; end
      exp_q16.push_back(model16(ra, rb));
      @(negedge clk);
      start16 = 1'b1; a16 = ra; b16 = rb;
      @(negedge clk);
      start16 = 1'b0;
      waited = 0;
      while (done16 !== 1'b1 && waited < W16 + 4) begin @(negedge clk); waited++; end
      e = exp_q16.pop_front();
      checks++;
      if (done16 !== 1'b1) begin
        errors++; $display("FAIL rand16_timeout a=%h b=%h", ra, rb);
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
      end else if ({brw16, diff16} !== e) begin
        errors++; $display("FAIL rand16 a=%h b=%h got=%b/%h exp=%b/%h", ra, rb, brw16, diff16, e[W16], e[W16-1:0]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    hs_a = 1'b0; hs_b = 1'b0;
    test_reset();
    test_half_subtractor();
    test_directed();
    test_start_mid_run();
    test_back_to_back();
    test_reset_mid_run();
    test_random_w8();
    test_random_w16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial subtractor: computes diff = a - b for two WIDTH-bit unsigned operands, one bit per clock, LSB first.
- The datapath is a single full-subtractor cell built from two half_subtractor instances plus a borrow flip-flop.
- It complements the team's combinational adder cells.
- It is the first sequential arithmetic unit in the library, driven by a start/done handshake from a controlling block or bench.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin a subtraction; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- busy  output  1  high while an operation is in progress (RUN or DONE).
- done  output  1  one-cycle pulse; diff/borrow_out valid from this cycle.
- diff  output  WIDTH  result, a - b modulo 2^WIDTH.
- borrow_out  output  1  final borrow; 1 when a < b (unsigned).

Behaviour:
- Reset (rst_n low, async): state=IDLE; busy=0, done=0, diff=0, borrow_out=0; shift registers, bit counter and borrow flop cleared. Release is synchronous to clk.
- States and transitions:
  - IDLE: on an edge with start=1, load a_sh<=a, b_sh<=b, res_sh<=0, brw<=0, cnt<=0; go to RUN. With start=0, remain in IDLE.
  - RUN: each edge processes bit a_sh[0], b_sh[0] with brw.
    - d = a0 ^ b0 ^ brw.
    - brw_next = (~a0 & b0) | (~(a0 ^ b0) & brw).
    - res_sh shifts right with d entering the MSB; a_sh and b_sh shift right; cnt increments.
    - On the edge where cnt==WIDTH-1, go to DONE and register diff<=final result and borrow_out<=brw_next.
  - DONE: done=1 for exactly this cycle; next edge goes to IDLE unconditionally.
- Latency: start accepted at edge k. RUN occupies edges k+1..k+WIDTH. done is high during the cycle after edge k+WIDTH. Start to done is WIDTH+1 cycles; the next start can be accepted at edge k+WIDTH+2.
- busy: 1 in RUN and DONE, 0 in IDLE. It is registered and rises in the cycle after the accepted start.
- start asserted in RUN or DONE is ignored, not queued. a and b may change freely after the accepted edge.
- diff and borrow_out are registered. They hold their last value until the next DONE overwrites them; they do not change during RUN.
- Arithmetic is unsigned modulo 2^WIDTH; borrow_out is the borrow out of the MSB. Example: 0 - 1 gives diff=all ones, borrow_out=1.
- Reset mid-operation (any state) aborts immediately to the reset values; no done pulse is produced.
- A held-high start restarts one cycle after DONE (back-to-back operation); each accepted start yields exactly one done pulse.

Decomposition:
- Shared header/package: state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2; default WIDTH.
- Counter width: $clog2(WIDTH)+1.
- One sub-module: half_subtractor (a, b -> diff=a^b, borrow=~a&b). It is instantiated twice with an OR on the borrows to form the per-bit cell. It is reusable and is unit-tested on its own with an exhaustive 4-vector truth-table bench.

Test Plan:
- Reset, then a=8'd5, b=8'd3, start for 1 cycle -> busy high for 9 cycles; done pulses exactly 9 cycles after start edge; diff=8'd2, borrow_out=0.
- a=8'd3, b=8'd5 -> diff=8'hFE, borrow_out=1.
- a=8'h00, b=8'h01 -> diff=8'hFF, borrow_out=1.
- a=8'hFF, b=8'h00 -> diff=8'hFF, borrow_out=0.
- Edge cases a=b=8'hA5 -> diff=8'h00, borrow_out=0.
- Start pulsed again mid-RUN with a=8'd9, b=8'd1 -> ignored; the original result is reported with a single done pulse.
- start held high over 3 operations -> 3 done pulses, spaced WIDTH+2 cycles apart.
- rst_n pulsed low at cycle 4 of RUN (a=8'd200, b=8'd100) -> outputs immediately 0, busy=0, no done pulse.
- Afterwards a fresh start with the same operands -> diff=8'd100, borrow_out=0.
- Random sweep (1000 pairs, WIDTH=8 and WIDTH=16) checked against a model: diff=(a-b) mod 2^W, borrow_out=(a<b).
